qmeas_frontend: RTL and testbench
=================================

Name: qmeas_frontend

Overview:
- Responder on the control loop's i_ref/q_measured interface; sits between the reference-search controller and the analog front-end.
- On request, latches i_ref, drives the current DAC and waits a fixed settling time.
- Then takes 2**AVG_LOG2 ADC conversions of the measured quantity and returns their truncated mean on q_measured with a one-cycle ready pulse.
- Supplies the controller's ready/q_measured pair so the controller can step its state only when a fresh measurement exists.

Parameters:
- BUS_WIDTH, 10, width of i_ref, DAC code, ADC sample and q_measured.
- SETTLE_CYCLES, 16, cycles between DAC load and first conversion start (must be >= 1).
- AVG_LOG2, 2, log2 of samples averaged per measurement (0..4).
- ADC_TIMEOUT, 64, max cycles waiting for adc_valid after adc_start (>= 1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req  in  1  measurement request; sampled only in IDLE.
- i_ref  in  BUS_WIDTH  current reference code; captured on accepted req.
- dac_code  out  BUS_WIDTH  registered DAC code.
- dac_load  out  1  one-cycle DAC update strobe.
- adc_start  out  1  one-cycle conversion start.
- adc_data  in  BUS_WIDTH  ADC result; valid with adc_valid.
- adc_valid  in  1  ADC result strobe.
- q_measured  out  BUS_WIDTH  averaged measurement; held between updates.
- ready  out  1  one-cycle pulse: measurement cycle complete.
- busy  out  1  high in every state except IDLE.
- timeout_err  out  1  high while the most recent measurement ended by timeout.

Behaviour:
- Reset (async, rst=0): state IDLE. dac_code, dac_load, adc_start, q_measured, ready, busy, timeout_err, accumulator and counters all 0.
- All outputs are registered.
- States: IDLE, LOAD, SETTLE, START, WAIT, DONE.
- IDLE: on req=1, capture i_ref into dac_code, clear accumulator and sample count, clear timeout_err, go to LOAD. req=0 holds in IDLE.
- LOAD: dac_load=1 for this cycle. Load settle counter with SETTLE_CYCLES-1. Go to SETTLE.
- SETTLE: decrement each cycle; at 0 go to START. Total SETTLE_CYCLES cycles.
- START: adc_start=1 for this cycle. Clear timeout counter. Go to WAIT.
- WAIT, adc_valid=1:
  - Add zero-extended adc_data to the accumulator (width BUS_WIDTH+AVG_LOG2; cannot overflow).
  - If this is the last sample: register q_measured = acc_next >> AVG_LOG2 (truncate) and go to DONE.
  - Otherwise go to START.
- WAIT, adc_valid=0: increment timeout counter. When ADC_TIMEOUT WAIT cycles have elapsed with no valid: set timeout_err=1, leave q_measured unchanged, go to DONE.
- DONE: ready=1 for exactly one cycle. Go to IDLE. req during DONE is ignored.
- Latency from the req-sampled cycle t0, with the ADC answering L cycles after adc_start: ready at t0 + 2 + SETTLE_CYCLES + N*(L+1), where N = 2**AVG_LOG2.
- req while busy: ignored, not queued. i_ref changes after capture have no effect.
- adc_valid outside WAIT: ignored.
- adc_valid in the same cycle the timeout count is reached: the sample wins (no timeout).
- Reset mid-operation: immediate return to IDLE, all outputs 0, no ready pulse.

Decomposition:
- Package qmeas_pkg: state enum, ready-latency function, accumulator width localparam.
- One sub-module, qmeas_averager: accumulator, sample counter, shift/truncate, clear/add/last interface.
- The FSM and counters stay in the top module.

Test Plan:
- Defaults, L=3, req at t0 with i_ref=512, ADC returns 100,101,102,103 -> dac_code=512, dac_load at t0+1, first adc_start at t0+18, ready at t0+34, q_measured=101, timeout_err=0.
- ADC returns 1023 four times -> q_measured=1023, no wrap. Then ADC returns 0,0,0,3 -> q_measured=0 (truncation).
- ADC never asserts adc_valid -> ready at t0+83, timeout_err=1, q_measured keeps its previous value. The next req clears timeout_err.
- req held high through a whole measurement and i_ref changed mid-settle -> exactly one measurement uses the captured i_ref. A new capture occurs in the cycle after ready.
- rst pulsed low during SETTLE -> all outputs 0 asynchronously, no ready. A subsequent req completes normally with the nominal latency.
- adc_valid pulses during SETTLE and in the cycle the timeout count is reached in WAIT -> the SETTLE pulses are ignored, the WAIT sample is accumulated, timeout_err=0.

Source files
------------

// File: rtl/qmeas_pkg.sv
// Shared types and helpers for the measurement front-end.
package qmeas_pkg;

    // Measurement sequencer states.
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETTLE,
        S_START,
        S_WAIT,
        S_DONE
    } state_t;

    // Default accumulator width: sum of 2**AVG_LOG2 samples never overflows.
    localparam int ACC_W_DEFAULT = 10 + 2;

    // Accumulator width for a given sample width and averaging depth.
    function automatic int acc_width(input int bus_width, input int avg_log2);
        return bus_width + avg_log2;
    endfunction

    // Cycles from req-sampled cycle to ready when the ADC answers lat cycles after start.
    function automatic int ready_latency(input int settle, input int avg_log2, input int lat);
        return 2 + settle + (1 << avg_log2) * (lat + 1);
    endfunction

endpackage

// File: rtl/qmeas_averager.sv
// Accumulates ADC samples and produces their truncated mean.
module qmeas_averager
    import qmeas_pkg::*;
#(
    parameter int BUS_WIDTH = 10,
    parameter int AVG_LOG2  = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_clear,
    input  logic                 i_add,
    input  logic [BUS_WIDTH-1:0] i_data,
    output logic                 o_last,
    output logic [BUS_WIDTH-1:0] o_mean
);
    localparam int ACC_W = acc_width(BUS_WIDTH, AVG_LOG2);
    localparam int CNT_W = AVG_LOG2 + 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'((1 << AVG_LOG2) - 1);

    logic [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic [ACC_W-1:0] w_sum;

    // Mean is taken from the sum including the sample arriving this cycle.
    assign w_sum  = r_acc + ACC_W'(i_data);
    assign o_mean = w_sum[ACC_W-1:AVG_LOG2];
    assign o_last = (r_cnt == LAST_IDX);

    // Accumulator and sample counter; clear wins over add.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (i_clear) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (i_add) begin
            r_acc <= w_sum;
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/qmeas_frontend.sv
// DAC load, settle, N-sample ADC average, ready pulse; timeout on a silent ADC.
module qmeas_frontend
    import qmeas_pkg::*;
#(
    parameter int BUS_WIDTH     = 10,
    parameter int SETTLE_CYCLES = 16,
    parameter int AVG_LOG2      = 2,
    parameter int ADC_TIMEOUT   = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req,
    input  logic [BUS_WIDTH-1:0] i_ref,
    output logic [BUS_WIDTH-1:0] dac_code,
    output logic                 dac_load,
    output logic                 adc_start,
    input  logic [BUS_WIDTH-1:0] adc_data,
    input  logic                 adc_valid,
    output logic [BUS_WIDTH-1:0] q_measured,
    output logic                 ready,
    output logic                 busy,
    output logic                 timeout_err
);
    localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
    localparam int TMO_W = $clog2(ADC_TIMEOUT + 1);

    state_t               r_state, w_next;
    logic [SET_W-1:0]     r_settle;
    logic [TMO_W-1:0]     r_tmo;
    logic [BUS_WIDTH-1:0] r_dac, r_q;
    logic                 r_load, r_start, r_ready, r_busy, r_terr;
    logic                 w_clear, w_add, w_last, w_tmo_hit;
    logic [BUS_WIDTH-1:0] w_mean;

    assign w_clear   = (r_state == S_IDLE) && req;
    assign w_add     = (r_state == S_WAIT) && adc_valid;
    // A sample arriving on the final wait cycle takes priority over the timeout.
    assign w_tmo_hit = (r_state == S_WAIT) && !adc_valid &&
                       (r_tmo == TMO_W'(ADC_TIMEOUT - 1));

    qmeas_averager #(.BUS_WIDTH(BUS_WIDTH), .AVG_LOG2(AVG_LOG2)) u_avg (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_clear (w_clear),
        .i_add   (w_add),
        .i_data  (adc_data),
        .o_last  (w_last),
        .o_mean  (w_mean)
    );

    // Next-state decode.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (req) w_next = S_LOAD;
            S_LOAD:   w_next = S_SETTLE;
            S_SETTLE: if (r_settle == '0) w_next = S_START;
            S_START:  w_next = S_WAIT;
            S_WAIT: begin
                if (adc_valid)      w_next = w_last ? S_DONE : S_START;
                else if (w_tmo_hit) w_next = S_DONE;
            end
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // State register; strobes are registered from the next state so they align with it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_load  <= 1'b0;
            r_start <= 1'b0;
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_load  <= (w_next == S_LOAD);
            r_start <= (w_next == S_START);
            r_ready <= (w_next == S_DONE);
            r_busy  <= (w_next != S_IDLE);
        end
    end

    // Datapath: captured reference, settle/timeout counters, result and error flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dac    <= '0;
            r_q      <= '0;
            r_settle <= '0;
            r_tmo    <= '0;
            r_terr   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (req) begin
                    r_dac  <= i_ref;
                    r_terr <= 1'b0;
                end
                S_LOAD:   r_settle <= SET_W'(SETTLE_CYCLES - 1);
                S_SETTLE: if (r_settle != '0) r_settle <= r_settle - 1'b1;
                S_START:  r_tmo <= '0;
                S_WAIT: begin
                    if (adc_valid) begin
                        if (w_last) r_q <= w_mean;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                        if (w_tmo_hit) r_terr <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dac_code    = r_dac;
    assign dac_load    = r_load;
    assign adc_start   = r_start;
    assign q_measured  = r_q;
    assign ready       = r_ready;
    assign busy        = r_busy;
    assign timeout_err = r_terr;

endmodule

// File: tb/tb_qmeas_frontend.sv
// Bench for qmeas_frontend: table vectors, random measurements, corner sequences.
module tb_qmeas_frontend;
    localparam int BW = 10;
    localparam int S  = 16;
    localparam int AV = 2;
    localparam int N  = 4;
    localparam int TO = 64;

    logic          clk = 1'b0;
    logic          rst, req;
    logic [BW-1:0] i_ref, dac_code, adc_data, q_measured;
    logic          dac_load, adc_start, adc_valid, ready, busy, timeout_err;

    always #5 clk = ~clk;

    qmeas_frontend #(.BUS_WIDTH(BW), .SETTLE_CYCLES(S), .AVG_LOG2(AV), .ADC_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req(req), .i_ref(i_ref),
        .dac_code(dac_code), .dac_load(dac_load), .adc_start(adc_start),
        .adc_data(adc_data), .adc_valid(adc_valid), .q_measured(q_measured),
        .ready(ready), .busy(busy), .timeout_err(timeout_err)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ADC model: answers adc_lat cycles after each adc_start with the next queued value.
    int            adc_lat  = 3;
    bit            adc_mute = 1'b0;
    int            adc_q[$];
    int            cd = -1;
    logic [BW-1:0] pend = '0;
    logic          m_valid = 1'b0, f_valid = 1'b0;
    logic [BW-1:0] m_data = '0, f_data = '0;
    assign adc_valid = m_valid | f_valid;
    assign adc_data  = f_valid ? f_data : m_data;

    always @(negedge clk) begin
        m_valid <= 1'b0;
        if (!rst) cd = -1;
        else begin
            if (cd > 0) begin
                cd = cd - 1;
                if (cd == 0) begin
                    m_valid <= 1'b1;
                    m_data  <= pend;
                    cd = -1;
                end
            end
            if (adc_start && !adc_mute) begin
                cd = adc_lat;
                if (adc_q.size() > 0) pend = BW'(adc_q.pop_front());
                else pend = '0;
            end
        end
    end

    int n_tests = 0, n_fail = 0;
    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    // One measurement; returns ready latency (-1 if none) and strobe offsets from t0.
    task automatic run_meas(input logic [BW-1:0] iref, input int lat, input bit mute,
                            output int r_lat, output int ld_t, output int st_t,
                            output logic to1, output logic busy1);
        int t0;
        adc_lat = lat; adc_mute = mute;
        @(negedge clk);
        t0 = cyc; req = 1'b1; i_ref = iref;
        @(negedge clk);
        req = 1'b0; i_ref = BW'($urandom);
        to1 = timeout_err; busy1 = busy;
        r_lat = -1; ld_t = -1; st_t = -1;
        for (int k = 1; k < 300; k++) begin
            if (dac_load && ld_t < 0) ld_t = cyc - t0;
            if (adc_start && st_t < 0) st_t = cyc - t0;
            if (ready) begin r_lat = cyc - t0; break; end
            @(negedge clk);
        end
    endtask

    typedef struct packed {
        logic [BW-1:0]      iref;
        int                 lat;
        bit                 mute;
        logic [3:0][BW-1:0] d;
        int                 exp_q;
        int                 exp_lat;
        bit                 exp_to;
    } vec_t;
    vec_t tbl[6];

    task automatic check_meas(input string tag, input vec_t v);
        int rl, lt, st; logic to1, b1;
        adc_q.delete();
        if (!v.mute) for (int j = 0; j < N; j++) adc_q.push_back(int'(v.d[j]));
        run_meas(v.iref, v.lat, v.mute, rl, lt, st, to1, b1);
        chk({tag, " latency"}, rl, v.exp_lat);
        chk({tag, " dac_load_t"}, lt, 1);
        chk({tag, " first_start_t"}, st, 2 + S);
        chk({tag, " q_measured"}, q_measured, v.exp_q);
        chk({tag, " timeout_err"}, timeout_err, v.exp_to);
        chk({tag, " dac_code"}, dac_code, v.iref);
        chk({tag, " terr_cleared"}, to1, 0);
        chk({tag, " busy_t1"}, b1, 1);
        @(negedge clk);
        chk({tag, " ready_one_cycle"}, ready, 0);
        chk({tag, " idle_busy"}, busy, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t v;
        int prev_q, sum, t0, rdy, rc, rl, lt, st;
        logic to1, b1;

        tbl[0] = '{10'd512,  3, 1'b0, {10'd103, 10'd102, 10'd101, 10'd100}, 101,  34, 1'b0};
        tbl[1] = '{10'd5,    3, 1'b0, {10'd1023, 10'd1023, 10'd1023, 10'd1023}, 1023, 34, 1'b0};
        tbl[2] = '{10'd7,    1, 1'b0, {10'd3, 10'd0, 10'd0, 10'd0}, 0, 26, 1'b0};
        tbl[3] = '{10'd1023, 5, 1'b0, {10'd41, 10'd30, 10'd20, 10'd10}, 25, 42, 1'b0};
        tbl[4] = '{10'd300,  3, 1'b1, {10'd0, 10'd0, 10'd0, 10'd0}, 25, 83, 1'b1};
        tbl[5] = '{10'd0,    2, 1'b0, {10'd3, 10'd3, 10'd3, 10'd3}, 3, 30, 1'b0};

        rst = 1'b0; req = 1'b0; i_ref = '0;
        repeat (3) @(negedge clk);
        chk("rst dac_code", dac_code, 0);   chk("rst dac_load", dac_load, 0);
        chk("rst adc_start", adc_start, 0); chk("rst q", q_measured, 0);
        chk("rst ready", ready, 0);         chk("rst busy", busy, 0);
        chk("rst terr", timeout_err, 0);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) check_meas($sformatf("vec%0d", i), tbl[i]);
        prev_q = 3;

        // Random measurements against the arithmetic model.
        for (int r = 0; r < 16; r++) begin
            v.iref = BW'($urandom);
            v.lat  = int'($urandom_range(1, 6));
            v.mute = ($urandom_range(0, 7) == 0);
            sum = 0;
            for (int j = 0; j < N; j++) begin
                v.d[j] = BW'($urandom);
                sum += int'(v.d[j]);
            end
            v.exp_to  = v.mute;
            v.exp_q   = v.mute ? prev_q : sum / N;
            v.exp_lat = v.mute ? (2 + S + 1 + TO) : (2 + S + N * (v.lat + 1));
            prev_q = v.exp_q;
            check_meas($sformatf("rnd%0d", r), v);
        end

        // req held through a measurement, i_ref changed mid-settle.
        adc_q.delete(); adc_mute = 1'b0; adc_lat = 2;
        foreach (tbl[0].d[j]) adc_q.push_back(j == 3 ? 12 : 8);
        repeat (4) adc_q.push_back(50);
        @(negedge clk);
        t0 = cyc; req = 1'b1; i_ref = 10'd111; rdy = -1; rc = 0;
        for (int k = 1; k < 300; k++) begin
            @(negedge clk);
            if (k == 5) i_ref = 10'd222;
            if (ready) begin rdy = cyc - t0; break; end
        end
        chk("hold latency", rdy, 30);
        chk("hold dac_code", dac_code, 111);
        chk("hold q", q_measured, 9);
        @(negedge clk);
        chk("hold idle_gap busy", busy, 0);
        t0 = cyc;
        @(negedge clk);
        chk("hold recapture load", dac_load, 1);
        chk("hold recapture code", dac_code, 222);
        req = 1'b0; rdy = -1;
        for (int k = 2; k < 300; k++) begin
            @(negedge clk);
            if (ready) begin rdy = cyc - t0; rc++; break; end
        end
        chk("hold second latency", rdy, 30);
        chk("hold second q", q_measured, 50);

        // Async reset during SETTLE aborts without a ready pulse.
        adc_q.delete();
        @(negedge clk);
        req = 1'b1; i_ref = 10'd77;
        @(negedge clk);
        req = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("arst dac_code", dac_code, 0); chk("arst dac_load", dac_load, 0);
        chk("arst adc_start", adc_start, 0); chk("arst q", q_measured, 0);
        chk("arst ready", ready, 0); chk("arst busy", busy, 0);
        chk("arst terr", timeout_err, 0);
        @(negedge clk);
        rst = 1'b1;
        rc = 0;
        repeat (120) begin
            @(negedge clk);
            if (ready) rc++;
        end
        chk("arst no ready", rc, 0);
        check_meas("post_rst", '{10'd600, 3, 1'b0, {10'd4, 10'd4, 10'd4, 10'd4}, 4, 34, 1'b0});

        // Stray valids in SETTLE ignored; valid on the final WAIT cycle beats the timeout.
        adc_q.delete(); adc_mute = 1'b1;
        @(negedge clk);
        t0 = cyc; req = 1'b1; i_ref = 10'd333; rdy = -1; st = -1;
        for (int k = 1; k < 300; k++) begin
            @(negedge clk);
            req = 1'b0;
            if (adc_start && st < 0) st = cyc - t0;
            if (ready) begin rdy = cyc - t0; break; end
            f_valid = (k == 5 || k == 10 || k == 82);
            f_data  = (k == 82) ? 10'd400 : 10'd999;
            if (k == 82) begin
                adc_mute = 1'b0; adc_lat = 1;
                repeat (3) adc_q.push_back(400);
            end
        end
        f_valid = 1'b0;
        chk("edge first_start_t", st, 18);
        chk("edge latency", rdy, 89);
        chk("edge q", q_measured, 400);
        chk("edge terr", timeout_err, 0);
        chk("edge dac_code", dac_code, 333);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
